// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: op codes, FSM states, amount width.
package shift_pkg;

  localparam int unsigned AMT_W = 5;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shifter: one SLL/SRL/SRA/ROR step of the work register.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (op)
      SH_SLL:  data_out = {data_in[DATA_W-2:0], 1'b0};
      SH_SRL:  data_out = {1'b0, data_in[DATA_W-1:1]};
      SH_SRA:  data_out = {data_in[DATA_W-1], data_in[DATA_W-1:1]};
      SH_ROR:  data_out = {data_in[0], data_in[DATA_W-1:1]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift unit: one bit position per clock, start/busy/done handshake,
// result held in the work register until the next accepted start.
module shift_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = shift_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       shift_amt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  import shift_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d, step_out;
  logic [AMT_W-1:0]  count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [AMT_W-1:0]  amt;

  // Only the low amount bits are significant; the mux output carries more.
  logic unused_amt;
  assign unused_amt = ^shift_amt[31:AMT_W];
  assign amt        = shift_amt[AMT_W-1:0];

  shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .op       (op_q),
    .data_in  (work_q),
    .data_out (step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = data_in;
          op_d    = op;
          count_d = amt;
          state_d = (amt != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        work_d  = step_out;
        count_d = count_q - 1'b1;
        if (count_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = work_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed table-driven bench for shift_unit plus hand sequences for busy-start and reset.
module tb_shift_unit;
  import shift_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] amt;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shift_amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[13];

  shift_unit #(
    .DATA_W (32),
    .AMT_W  (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shift_amt (shift_amt),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start is raised just after one edge and accepted on the next (edge A);
  // done must appear after edge A+lat, then clear one cycle later.
  task automatic run_vec(input vec_t v, input string name);
    int k;
    @(posedge clk);
    #1;
    start     = 1'b1;
    op        = v.op;
    data_in   = v.data;
    shift_amt = v.amt;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op        = ~v.op;
    data_in   = ~v.data;
    shift_amt = 32'h0000_0003;
    check({name, " busy_after_accept"}, 32'(busy), 32'd1);
    k = 0;
    @(negedge clk);
    while (!done && k < 100) begin
      k++;
      @(negedge clk);
    end
    check({name, " latency"}, 32'(k), 32'(v.lat));
    check({name, " result"}, result, v.exp);
    @(negedge clk);
    check({name, " busy_low"}, 32'(busy), 32'd0);
    check({name, " done_pulse_ends"}, 32'(done), 32'd0);
    @(negedge clk);
    check({name, " result_held"}, result, v.exp);
  endtask

  initial begin
    int dones;
    vecs[0]  = '{SH_SLL, 32'h0000_0001, 32'd4,          32'h0000_0010, 4};
    vecs[1]  = '{SH_SRA, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 31};
    vecs[2]  = '{SH_SRL, 32'h8000_0000, 32'd31,         32'h0000_0001, 31};
    vecs[3]  = '{SH_ROR, 32'h0000_0001, 32'd1,          32'h8000_0000, 1};
    vecs[4]  = '{SH_ROR, 32'h0000_0001, 32'h0000_0025,  32'h0800_0000, 5};
    vecs[5]  = '{SH_SLL, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 0};
    vecs[6]  = '{SH_SRA, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 0};
    vecs[7]  = '{SH_SRA, 32'h8000_0010, 32'd4,          32'hF800_0001, 4};
    vecs[8]  = '{SH_ROR, 32'h1234_5678, 32'd8,          32'h7812_3456, 8};
    vecs[9]  = '{SH_SLL, 32'hFFFF_FFFF, 32'd31,         32'h8000_0000, 31};
    vecs[10] = '{SH_SRL, 32'h7FFF_FFFF, 32'd3,          32'h0FFF_FFFF, 3};
    vecs[11] = '{SH_SRA, 32'h4000_0000, 32'd2,          32'h1000_0000, 2};
    vecs[12] = '{SH_ROR, 32'hDEAD_BEEF, 32'hFFFF_FFE0,  32'hDEAD_BEEF, 0};

    reset     = 1'b0;
    start     = 1'b0;
    op        = SH_SLL;
    data_in   = '0;
    shift_amt = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Starts raised during SHIFT and during DONE must be dropped.
    @(posedge clk);
    #1;
    start     = 1'b1;
    op        = SH_SLL;
    data_in   = 32'h0000_0001;
    shift_amt = 32'd3;
    @(posedge clk);
    #1;
    start     = 1'b0;
    data_in   = 32'hAAAA_AAAA;
    op        = SH_SRL;
    shift_amt = 32'd2;
    dones     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 1 || i == 3) start = 1'b1;
      if (i == 2 || i == 4) start = 1'b0;
    end
    check("busy_start done_count", 32'(dones), 32'd1);
    check("busy_start result", result, 32'h0000_0008);
    check("busy_start idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a 20-bit SLL.
    @(posedge clk);
    #1;
    start     = 1'b1;
    op        = SH_SLL;
    data_in   = 32'h0000_0001;
    shift_amt = 32'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'd1);
    check("pre_reset result", result, 32'h0000_0020);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset busy", 32'(busy), 32'd0);
    check("async_reset done", 32'(done), 32'd0);
    check("async_reset result", result, 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("lost_op no_done", 32'(dones), 32'd0);
    run_vec('{SH_SRL, 32'hF000_0000, 32'd4, 32'h0F00_0000, 4}, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
